// File: rtl/mio_pkg.sv
// Shared definitions for the mio_bus memory/IO stage.
// Contents: FSM state encoding, IO register offsets within IO space, default IO base nibble.
package mio_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RAM_WAIT = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  localparam logic [31:0] GPIO_OFS = 32'h0000_0000;
  localparam logic [31:0] CNT_OFS  = 32'h0000_0004;

  localparam logic [3:0] IO_BASE_HI_DEF = 4'hF;

endpackage

// File: rtl/mio_bus_if.sv
// CPU-side request/response bundle of the memory/IO bus.
// Signals: cpu_mio, mem_r, mem_w, addr, wdata (CPU -> bus); rdata, mio_ready (bus -> CPU).
// Modports: master = CPU side, slave = mio_bus side.
interface mio_bus_if;
  logic        cpu_mio;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;

  modport master (
    output cpu_mio, mem_r, mem_w, addr, wdata,
    input  rdata, mio_ready
  );

  modport slave (
    input  cpu_mio, mem_r, mem_w, addr, wdata,
    output rdata, mio_ready
  );
endinterface

// File: rtl/mio_io_regs.sv
// On-chip IO registers: GPIO output register, optional free-running cycle counter and the
// combinational IO read mux.
// Ports: i_clk, i_rst_n (async active-low), i_we (one-cycle write strobe), i_ofs (word-aligned
//        offset into IO space), i_wdata (low write data half), i_sw (switches),
//        o_gpio_out (GPIO register), o_rdata (read mux result for i_ofs).
// Build option: MIO_CYCLE_CNT_EN adds the 32-bit cycle counter at CNT_OFS; otherwise that
//               offset reads as zero.
module mio_io_regs
  import mio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [31:0] i_ofs,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_sw,
  output logic [15:0] o_gpio_out,
  output logic [31:0] o_rdata
);

  logic [15:0] r_gpio;
  logic [31:0] w_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpio <= '0;
    end else if (i_we && (i_ofs == GPIO_OFS)) begin
      r_gpio <= i_wdata;
    end
  end

`ifdef MIO_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Free-running; wraps naturally from all-ones to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign w_cnt = r_cycle_cnt;
`else
  assign w_cnt = '0;
`endif

  // GPIO offset reads the switches, not the GPIO register.
  always_comb begin
    o_rdata = '0;
    if (i_ofs == GPIO_OFS) begin
      o_rdata = {16'h0000, i_sw};
    end else if (i_ofs == CNT_OFS) begin
      o_rdata = w_cnt;
    end
  end

  assign o_gpio_out = r_gpio;

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus stage behind the multicycle CPU. Decodes each accepted request to block RAM or
// to the IO registers, sequences RAM wait states and reports completion on mio_ready.
// Ports: i_clk, i_rst_n (async active-low), bus (mio_bus_if.slave: CPU request/response),
//        o_ram_addr/o_ram_din/o_ram_we, i_ram_dout (block RAM port), i_sw (switches),
//        o_gpio_out (GPIO register), o_misalign/o_rw_conflict (sticky error flags).
// Build option: MIO_CYCLE_CNT_EN enables the cycle counter inside mio_io_regs.
module mio_bus
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [3:0]  IO_BASE_HI  = IO_BASE_HI_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mio_bus_if.slave          bus,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_din,
  output logic              o_ram_we,
  input  logic [31:0]       i_ram_dout,
  input  logic [15:0]       i_sw,
  output logic [15:0]       o_gpio_out,
  output logic              o_misalign,
  output logic              o_rw_conflict
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic [2:0]        r_wait_cnt;
  logic              r_rd_pend;
  logic [31:0]       r_rdata;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_din;
  logic              r_ram_we;
  logic              r_misalign;
  logic              r_rw_conflict;

  logic        w_req;
  logic        w_is_io;
  logic        w_accept;
  logic        w_rd_only;
  logic        w_io_we;
  logic [31:0] w_io_ofs;
  logic [31:0] w_io_rdata;

  assign w_req     = bus.cpu_mio & (bus.mem_r | bus.mem_w);
  assign w_is_io   = (bus.addr[31:28] == IO_BASE_HI);
  assign w_accept  = (r_state == IDLE) & w_req;
  // A simultaneous read+write is treated as a write; the read is dropped.
  assign w_rd_only = bus.mem_r & ~bus.mem_w;
  assign w_io_we   = w_accept & w_is_io & bus.mem_w;
  assign w_io_ofs  = {4'h0, bus.addr[27:2], 2'b00};

  mio_io_regs u_io_regs (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (w_io_we),
    .i_ofs      (w_io_ofs),
    .i_wdata    (bus.wdata[15:0]),
    .i_sw       (i_sw),
    .o_gpio_out (o_gpio_out),
    .o_rdata    (w_io_rdata)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_d = w_is_io ? DONE : RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        if (r_wait_cnt == 3'd1) begin
          w_state_d = DONE;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_rd_pend     <= 1'b0;
      r_rdata       <= '0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_ram_we      <= 1'b0;
      r_misalign    <= 1'b0;
      r_rw_conflict <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        if (bus.addr[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
        if (bus.mem_r && bus.mem_w) begin
          r_rw_conflict <= 1'b1;
        end
        if (w_is_io) begin
          if (w_rd_only) begin
            r_rdata <= w_io_rdata;
          end
        end else begin
          // Upper address bits above the RAM word index are ignored, so RAM aliases.
          r_ram_addr <= bus.addr[RAM_AW+1:2];
          r_ram_din  <= bus.wdata;
          r_ram_we   <= bus.mem_w;
          r_wait_cnt <= 3'(RAM_LATENCY);
          r_rd_pend  <= w_rd_only;
        end
      end else if (r_state == RAM_WAIT) begin
        // The write strobe lives for the first wait cycle only; a dropped request still completes.
        r_ram_we   <= 1'b0;
        r_wait_cnt <= r_wait_cnt - 3'd1;
        if ((r_wait_cnt == 3'd1) && r_rd_pend) begin
          r_rdata <= i_ram_dout;
        end
      end
    end
  end

  assign bus.mio_ready = ((r_state == IDLE) & ~w_req) | (r_state == DONE);
  assign bus.rdata     = r_rdata;

  assign o_ram_addr    = r_ram_addr;
  assign o_ram_din     = r_ram_din;
  assign o_ram_we      = r_ram_we;
  assign o_misalign    = r_misalign;
  assign o_rw_conflict = r_rw_conflict;

endmodule

// File: tb/tb_mio_bus.sv
// Self-checking bench for mio_bus with RAM_LATENCY=2 and a behavioural synchronous RAM.
module tb_mio_bus;

  localparam int unsigned Aw  = 10;
  localparam int unsigned Lat = 2;

  logic          clk;
  logic          rst_n;
  logic [Aw-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [31:0]   ram_dout;
  logic [15:0]   sw;
  logic [15:0]   gpio_out;
  logic          misalign;
  logic          rw_conflict;

  logic [31:0] ram_mem [0:(1<<Aw)-1];
  logic [31:0] sb_q [$];
  logic [31:0] exp_rdata;

  int n_checks;
  int n_fail;

  mio_bus_if u_if ();

  mio_bus #(
    .RAM_AW      (Aw),
    .RAM_LATENCY (Lat),
    .IO_BASE_HI  (4'hF)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (u_if),
    .o_ram_addr    (ram_addr),
    .o_ram_din     (ram_din),
    .o_ram_we      (ram_we),
    .i_ram_dout    (ram_dout),
    .i_sw          (sw),
    .o_gpio_out    (gpio_out),
    .o_misalign    (misalign),
    .o_rw_conflict (rw_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync RAM: address is registered in the DUT, one more register here gives total latency 2.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic drop_req();
    u_if.cpu_mio = 1'b0;
    u_if.mem_r   = 1'b0;
    u_if.mem_w   = 1'b0;
  endtask

  // Drives one request at a falling edge (cycle 0) and waits for mio_ready.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output int we_cnt,
                        output logic [Aw-1:0] we_addr, output logic [31:0] we_din,
                        output logic rdy0);
    @(negedge clk);
    u_if.cpu_mio = 1'b1;
    u_if.mem_r   = r;
    u_if.mem_w   = w;
    u_if.addr    = a;
    u_if.wdata   = d;
    #1 rdy0 = u_if.mio_ready;
    lat = -1; we_cnt = 0; we_addr = '0; we_din = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
      if (u_if.mio_ready) begin
        lat = k;
        break;
      end
    end
    rd = u_if.rdata;
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({u_if.mio_ready, ram_we, misalign, rw_conflict} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/we/mis/conf=%b want 1000",
               {u_if.mio_ready, ram_we, misalign, rw_conflict});
    end
    n_checks++;
    if (u_if.rdata !== 32'h0 || gpio_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h gpio=%h want 0/0", u_if.rdata, gpio_out);
    end
    n_checks++;
    if (ram_addr !== '0 || ram_din !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram: addr=%h din=%h want 0/0", ram_addr, ram_din);
    end
  endtask

  task automatic test_ram_read();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    ram_mem[5] = 32'hDEAD_BEEF;
    exp_rdata = 32'hDEAD_BEEF;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (r0 !== 1'b0 || lat != Lat + 1) begin
      n_fail++;
      $display("FAIL ram_read_latency: rdy0=%b lat=%0d want 0/%0d", r0, lat, Lat + 1);
    end
    n_checks++;
    if (rd !== sb_q[0]) begin
      n_fail++;
      $display("FAIL ram_read_data: got %h want %h", rd, sb_q[0]);
    end
    void'(sb_q.pop_front());
    n_checks++;
    if (ram_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL ram_read_addr: got %0d want 5", ram_addr);
    end
    // Address bit 12 lies above the RAM index and must alias to word 6.
    ram_mem[6] = 32'h0BAD_CAFE;
    exp_rdata = 32'h0BAD_CAFE;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'h0000_1018, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0] || ram_addr !== 10'd6) begin
      n_fail++;
      $display("FAIL ram_read_wrap: got %h @%0d want %h @6", rd, ram_addr, sb_q[0]);
    end
    void'(sb_q.pop_front());
  endtask

  task automatic test_ram_write();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    sb_q.push_back(exp_rdata);
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (wc != 1 || wa !== 10'd8 || wd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL ram_write_strobe: cnt=%0d addr=%0d din=%h want 1/8/12345678", wc, wa, wd);
    end
    n_checks++;
    if (lat != Lat + 1) begin
      n_fail++;
      $display("FAIL ram_write_latency: got %0d want %0d", lat, Lat + 1);
    end
    n_checks++;
    if (rd !== sb_q[0]) begin
      n_fail++;
      $display("FAIL ram_write_rdata_held: got %h want %h", rd, sb_q[0]);
    end
    void'(sb_q.pop_front());
    n_checks++;
    if (ram_mem[8] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL ram_write_mem: got %h want 12345678", ram_mem[8]);
    end
    exp_rdata = 32'h1234_5678;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0]) begin
      n_fail++;
      $display("FAIL ram_write_readback: got %h want %h", rd, sb_q[0]);
    end
    void'(sb_q.pop_front());
  endtask

  task automatic test_gpio();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    sb_q.push_back(exp_rdata);
    access(1'b0, 1'b1, 32'hF000_0000, 32'h0000_A5A5, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (r0 !== 1'b0 || lat != 1 || gpio_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL gpio_write: rdy0=%b lat=%0d gpio=%h want 0/1/a5a5", r0, lat, gpio_out);
    end
    n_checks++;
    if (rd !== sb_q[0] || wc != 0) begin
      n_fail++;
      $display("FAIL gpio_write_side: rdata=%h we_cnt=%0d want %h/0", rd, wc, sb_q[0]);
    end
    void'(sb_q.pop_front());
    sw = 16'h00FF;
    exp_rdata = 32'h0000_00FF;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0] || lat != 1) begin
      n_fail++;
      $display("FAIL gpio_read_sw: got %h lat=%0d want %h lat=1", rd, lat, sb_q[0]);
    end
    void'(sb_q.pop_front());
    exp_rdata = 32'h0;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'hF000_0008, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0]) begin
      n_fail++;
      $display("FAIL io_read_other: got %h want %h", rd, sb_q[0]);
    end
    void'(sb_q.pop_front());
    access(1'b0, 1'b1, 32'hF000_0008, 32'h0000_FFFF, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (gpio_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL io_write_other: gpio=%h want a5a5", gpio_out);
    end
  endtask

  task automatic test_cpu_mio_gate();
    int not_ready;
    not_ready = 0;
    @(negedge clk);
    u_if.cpu_mio = 1'b0;
    u_if.mem_r   = 1'b1;
    u_if.mem_w   = 1'b1;
    u_if.addr    = 32'h0000_0002;
    u_if.wdata   = 32'h5555_5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (!u_if.mio_ready || ram_we) not_ready++;
      @(negedge clk);
    end
    drop_req();
    n_checks++;
    if (not_ready != 0 || misalign !== 1'b0 || rw_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_mio_gate: bad_cycles=%0d mis=%b conf=%b want 0/0/0",
               not_ready, misalign, rw_conflict);
    end
  endtask

  task automatic test_conflict();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b1, 32'h0000_0006, 32'hCAFE_F00D, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (wc != 1 || wa !== 10'd1 || wd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL conflict_write: cnt=%0d addr=%0d din=%h want 1/1/cafef00d", wc, wa, wd);
    end
    n_checks++;
    if (rd !== sb_q[0]) begin
      n_fail++;
      $display("FAIL conflict_read_suppressed: got %h want %h", rd, sb_q[0]);
    end
    void'(sb_q.pop_front());
    n_checks++;
    if (misalign !== 1'b1 || rw_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_flags: mis=%b conf=%b want 1/1", misalign, rw_conflict);
    end
    exp_rdata = 32'hCAFE_F00D;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0] || misalign !== 1'b1 || rw_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_sticky: rdata=%h mis=%b conf=%b want %h/1/1",
               rd, misalign, rw_conflict, sb_q[0]);
    end
    void'(sb_q.pop_front());
  endtask

  task automatic test_drop();
    int lat;
    @(negedge clk);
    u_if.cpu_mio = 1'b1;
    u_if.mem_r   = 1'b0;
    u_if.mem_w   = 1'b1;
    u_if.addr    = 32'h0000_0040;
    u_if.wdata   = 32'h7777_1111;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) drop_req();
      #1;
      if (u_if.mio_ready) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    n_checks++;
    if (lat != Lat + 1 || ram_mem[16] !== 32'h7777_1111) begin
      n_fail++;
      $display("FAIL drop_mid_wait: lat=%0d mem=%h want %0d/77771111", lat, ram_mem[16], Lat + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    for (int i = 0; i < 4; i++) begin
      ram_mem[40 + i] = $urandom;
      exp_rdata = ram_mem[40 + i];
      sb_q.push_back(exp_rdata);
      access(1'b1, 1'b0, 32'(4 * (40 + i)), 32'h0, lat, rd, wc, wa, wd, r0);
      n_checks++;
      if (rd !== sb_q[0] || lat != Lat + 1) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %h lat=%0d want %h lat=%0d",
                 i, rd, lat, sb_q[0], Lat + 1);
      end
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_cycle_cnt();
    int lat, wc; logic [31:0] rd1, rd2, wd; logic [Aw-1:0] wa; logic r0;
    access(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, rd1, wc, wa, wd, r0);
    repeat (7) @(negedge clk);
    access(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, rd2, wc, wa, wd, r0);
`ifdef MIO_CYCLE_CNT_EN
    n_checks++;
    if (rd2 - rd1 !== 32'd10) begin
      n_fail++;
      $display("FAIL cycle_cnt_delta: got %0d want 10", rd2 - rd1);
    end
    exp_rdata = rd2;
`else
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      n_fail++;
      $display("FAIL cycle_cnt_absent: got %h/%h want 0/0", rd1, rd2);
    end
    exp_rdata = 32'h0;
`endif
  endtask

  task automatic test_reset_mid();
    int lat, wc; logic [31:0] rd, wd; logic [Aw-1:0] wa; logic r0;
    @(negedge clk);
    u_if.cpu_mio = 1'b1;
    u_if.mem_r   = 1'b0;
    u_if.mem_w   = 1'b1;
    u_if.addr    = 32'h0000_0030;
    u_if.wdata   = 32'h9999_0000;
    @(negedge clk);
    #1;
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: ram_we=%b want 1", ram_we);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_we !== 1'b0 || gpio_out !== 16'h0 || u_if.rdata !== 32'h0 ||
        misalign !== 1'b0 || rw_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: we=%b gpio=%h rdata=%h mis=%b conf=%b want 0/0/0/0/0",
               ram_we, gpio_out, u_if.rdata, misalign, rw_conflict);
    end
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (u_if.mio_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", u_if.mio_ready);
    end
    sw = 16'h1234;
    exp_rdata = 32'h0000_1234;
    sb_q.push_back(exp_rdata);
    access(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, wc, wa, wd, r0);
    n_checks++;
    if (rd !== sb_q[0] || lat != 1) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %h lat=%0d want %h lat=1", rd, lat, sb_q[0]);
    end
    void'(sb_q.pop_front());
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_rdata = 32'h0;
    rst_n     = 1'b0;
    sw        = 16'h0;
    u_if.addr  = 32'h0;
    u_if.wdata = 32'h0;
    drop_req();
    for (int i = 0; i < (1 << Aw); i++) ram_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_ram_read();
    test_ram_write();
    test_gpio();
    test_cpu_mio_gate();
    test_conflict();
    test_drop();
    test_back_to_back();
    test_cycle_cnt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_bus.md
Name: mio_bus

Overview:
- Memory/IO bus stage directly downstream of the multicycle CPU control FSM and datapath.
- Accepts the CPU's registered mem_r/mem_w/cpu_mio requests and decodes the address to block RAM or the on-chip IO registers (GPIO, switches, cycle counter).
- Sequences RAM wait states and returns mio_ready plus read data.
- The control FSM gates every state transition on mio_ready, so mio_ready is low exactly while an accepted access is outstanding.

Parameters:
- RAM_AW, 10, RAM word-address width (depth 2^RAM_AW words).
- RAM_LATENCY, 1, synchronous RAM read latency in cycles (1..4).
- IO_BASE_HI, 4'hF, addr[31:28] value selecting IO space.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_mio  in  1  CPU owns bus this cycle.
- mem_r  in  1  read request (held until mio_ready).
- mem_w  in  1  write request (held until mio_ready).
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- mio_ready  out  1  access complete / bus idle (combinational from state and request).
- ram_addr  out  RAM_AW  RAM word address, registered.
- ram_din  out  32  RAM write data, registered.
- ram_we  out  1  RAM write strobe, registered, one cycle.
- ram_dout  in  32  RAM read data.
- sw  in  16  switch inputs.
- gpio_out  out  16  LED/GPIO register.
- misalign  out  1  sticky: an access had addr[1:0]!=0.
- rw_conflict  out  1  sticky: mem_r and mem_w both high on acceptance.

Behaviour:
- Request definition: req = cpu_mio & (mem_r | mem_w).
- States: IDLE, RAM_WAIT, DONE.
- mio_ready = (IDLE & ~req) | DONE.
- IDLE & req, RAM target (addr[31:28] != IO_BASE_HI):
  - register ram_addr = addr[RAM_AW+1:2]; higher bits ignored, so addresses wrap.
  - register ram_din = wdata; ram_we = mem_w.
  - load wait counter = RAM_LATENCY; go to RAM_WAIT.
- RAM_WAIT: ram_we forced 0 after its first cycle; decrement counter; at counter==1 capture rdata <= ram_dout (reads only) and go to DONE.
- IDLE & req, IO target: complete in the same edge, then go to DONE.
  - 0xF0000000: write sets gpio_out = wdata[15:0]; read returns {16'h0, sw}.
  - 0xF0000004: read returns cycle_cnt; write ignored.
  - Other IO offsets: read returns 0; write ignored.
- DONE: mio_ready=1 for exactly one cycle, then IDLE unconditionally. The CPU changes its request on this edge, so the request is never re-accepted.
- Latency, request first seen in cycle 0: IO access has DONE in cycle 1; RAM access has DONE in cycle RAM_LATENCY+1.
- rdata holds its value until the next read completes; writes do not alter rdata.
- Simultaneous mem_r & mem_w: write is performed, read suppressed, rw_conflict set.
- Misaligned address: access uses the aligned word; misalign set.
- Sticky flags clear only on reset.
- Request dropped mid-RAM_WAIT: the access still completes; the already-issued write is not cancelled.
- cpu_mio=0 in IDLE: mem_r/mem_w ignored, mio_ready=1.
- cycle_cnt: 32-bit, +1 every clock, wraps 0xFFFFFFFF to 0.
- Reset (async assert, any state): state=IDLE, rdata=0, ram_addr=0, ram_din=0, ram_we=0, gpio_out=0, misalign=0, rw_conflict=0, cycle_cnt=0. mio_ready is then 1 unless req.

Optional Feature:
- MIO_CYCLE_CNT_EN defined: 32-bit cycle counter present, readable at 0xF0000004.
- MIO_CYCLE_CNT_EN undefined: no counter logic; reads of 0xF0000004 return 0.

Decomposition:
- Shared package mio_pkg holds:
  - state encoding (IDLE=2'd0, RAM_WAIT=2'd1, DONE=2'd2);
  - IO offsets GPIO_OFS=32'h0, CNT_OFS=32'h4;
  - IO_BASE_HI default.
- One natural sub-module: mio_io_regs. It holds gpio_out, cycle_cnt and the IO read mux, driven by a one-cycle IO write strobe and address offset.

Test Plan:
- RAM read, RAM_LATENCY=2, preloaded word[5]=0xDEADBEEF, mem_r=1, cpu_mio=1, addr=0x14 -> mio_ready low cycles 0-2, high cycle 3 with rdata=0xDEADBEEF, ram_addr=5.
- RAM write, addr=0x20, wdata=0x12345678 -> ram_we high exactly one cycle with ram_addr=8, ram_din=0x12345678; mio_ready high in cycle RAM_LATENCY+1; rdata unchanged.
- GPIO: write 0xF0000000 with wdata=0x0000A5A5 -> gpio_out=0xA5A5 after cycle 1. Read with sw=0x00FF -> rdata=0x000000FF, DONE in cycle 1.
- Conflict/misalign: mem_r=mem_w=1, addr=0x0000_0006 -> write to word 1, rw_conflict=1, misalign=1, both held through later clean accesses.
- Reset mid-operation: assert reset during RAM_WAIT -> state IDLE, ram_we=0, gpio_out=0, rdata=0. After release with no request, mio_ready=1.
- Cycle counter with MIO_CYCLE_CNT_EN: read 0xF0000004 at two points 10 clocks apart -> difference 10. Without the macro -> rdata=0.
